// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_pkg
// Description : Shared widths, default parameters and helpers for the
//               tick_scheduler block.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    localparam int FRAME_CNT_W      = 16;
    localparam int OVR_W            = 8;
    localparam int DIV_W            = 8;

    localparam int DEF_PAC_DIV      = 4;
    localparam int DEF_GHOST_DIV    = 5;
    localparam int DEF_WDOG_CYCLES  = 1_700_000;

    // Adds 0..2 overrun strobes and clamps at the all-ones value.
    function automatic logic [OVR_W-1:0] sat_add_ovr(
        input logic [OVR_W-1:0] a,
        input logic [1:0]       n
    );
        logic [OVR_W:0] w_sum;
        w_sum = {1'b0, a} + {{(OVR_W-1){1'b0}}, n};
        return w_sum[OVR_W] ? {OVR_W{1'b1}} : w_sum[OVR_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_channel.sv
`default_nettype none
// ============================================================================
// Module      : step_channel
// Description : Divides enabled frame ticks by DIV and raises a step request
//               held until acknowledged; flags steps lost to a busy request.
// Revision    : 1.0 - initial release
// ============================================================================
module step_channel
    import tick_pkg::*;
#(
    parameter int DIV = DEF_PAC_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic enable,
    input  logic ack,
    output logic req,
    output logic overrun
);

    localparam logic [DIV_W-1:0] c_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_req;
    logic             w_fire;

    assign w_fire  = tick & enable & (r_cnt == c_LAST);
    // An ack in the firing cycle retires the old step, so only an unacked
    // pending request counts as lost.
    assign overrun = w_fire & r_req & ~ack;
    assign req     = r_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_req <= 1'b0;
        end else begin
            if (tick && enable) begin
                r_cnt <= w_fire ? '0 : r_cnt + DIV_W'(1);
            end
            if (w_fire) begin
                r_req <= 1'b1;
            end else if (ack) begin
                r_req <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Converts the slow game-tick toggle into frame ticks, derives
//               Pac-Man and ghost step requests, counts overruns and watches
//               for a stalled tick source.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int PAC_DIV     = DEF_PAC_DIV,
    parameter int GHOST_DIV   = DEF_GHOST_DIV,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   slow_in,
    input  logic                   enable,
    input  logic                   pac_ack,
    input  logic                   ghost_ack,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   pac_req,
    output logic                   ghost_req,
    output logic [OVR_W-1:0]       overrun_cnt,
    output logic                   tick_lost
);

    localparam int                c_WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX  = c_WDOG_W'(WDOG_CYCLES);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_sync3;
    logic [2:0]             r_warm;
    logic                   r_frame_tick;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [OVR_W-1:0]       r_ovr_cnt;
    logic [c_WDOG_W-1:0]    r_wdog;
    logic                   r_tick_lost;
    logic                   w_rise;
    logic                   w_pac_ovr;
    logic                   w_ghost_ovr;
    logic [1:0]             w_ovr_sum;

    // The detector waits until sync3 holds a real sample, so a level that is
    // already high when reset releases is not mistaken for a rising edge.
    assign w_rise    = r_sync2 & ~r_sync3 & r_warm[2];
    assign w_ovr_sum = {1'b0, w_pac_ovr} + {1'b0, w_ghost_ovr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_warm       <= '0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
            r_ovr_cnt    <= '0;
            r_wdog       <= '0;
            r_tick_lost  <= 1'b0;
        end else begin
            r_sync1      <= slow_in;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_warm       <= {r_warm[1:0], 1'b1};
            r_frame_tick <= w_rise;
            if (r_frame_tick) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            r_ovr_cnt <= sat_add_ovr(r_ovr_cnt, w_ovr_sum);
            if (r_frame_tick) begin
                r_wdog <= '0;
            end else if (r_wdog != c_WDOG_MAX) begin
                r_wdog <= r_wdog + c_WDOG_W'(1);
            end
            if (!r_frame_tick && (r_wdog == c_WDOG_LAST)) begin
                r_tick_lost <= 1'b1;
            end
        end
    end

    step_channel #(.DIV(PAC_DIV)) u_pac (
        .clk     (clk),
        .reset   (reset),
        .tick    (r_frame_tick),
        .enable  (enable),
        .ack     (pac_ack),
        .req     (pac_req),
        .overrun (w_pac_ovr)
    );

    step_channel #(.DIV(GHOST_DIV)) u_ghost (
        .clk     (clk),
        .reset   (reset),
        .tick    (r_frame_tick),
        .enable  (enable),
        .ack     (ghost_ack),
        .req     (ghost_req),
        .overrun (w_ghost_ovr)
    );

    assign frame_tick  = r_frame_tick;
    assign frame_cnt   = r_frame_cnt;
    assign overrun_cnt = r_ovr_cnt;
    assign tick_lost   = r_tick_lost;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Scoreboard bench for tick_scheduler with a tick-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PAC_DIV   = 4;
    localparam int GHOST_DIV = 5;
    localparam int WDOG      = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        slow_in;
    logic        enable;
    logic        pac_ack;
    logic        ghost_ack;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic        pac_req;
    logic        ghost_req;
    logic [7:0]  overrun_cnt;
    logic        tick_lost;

    tick_scheduler #(
        .PAC_DIV     (PAC_DIV),
        .GHOST_DIV   (GHOST_DIV),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_in     (slow_in),
        .enable      (enable),
        .pac_ack     (pac_ack),
        .ghost_ack   (ghost_ack),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt),
        .pac_req     (pac_req),
        .ghost_req   (ghost_req),
        .overrun_cnt (overrun_cnt),
        .tick_lost   (tick_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tcyc;
        logic [15:0] fc;
        logic        preq;
        logic        greq;
        logic [7:0]  ovr;
        logic        lost;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: ticks seen, enabled ticks since last step, pending flags.
    int m_fc, m_pac_n, m_ghost_n, m_ovr;
    bit m_preq, m_greq, m_lost;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fc = 0; m_pac_n = 0; m_ghost_n = 0; m_ovr = 0;
        m_preq = 0; m_greq = 0; m_lost = 0;
    endfunction

    function automatic void model_tick(input bit en, input bit ack_fire);
        bit pac_fire, ghost_fire;
        pac_fire = 0; ghost_fire = 0;
        m_fc = (m_fc + 1) % 65536;
        if (en) begin
            m_pac_n++;
            m_ghost_n++;
            if (m_pac_n == PAC_DIV)   begin pac_fire = 1;   m_pac_n = 0;   end
            if (m_ghost_n == GHOST_DIV) begin ghost_fire = 1; m_ghost_n = 0; end
        end
        if (pac_fire) begin
            if (m_preq && !ack_fire) m_ovr++;
            m_preq = 1;
        end else if (ack_fire) begin
            m_preq = 0;
        end
        if (ghost_fire) begin
            if (m_greq) m_ovr++;
            m_greq = 1;
        end
        if (m_ovr > 255) m_ovr = 255;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One slow_in rising edge; ack_fire drives pac_ack in the frame_tick cycle.
    task automatic do_tick(input bit en, input bit ack_fire, input int gap);
        exp_t e;
        enable  = en;
        slow_in = 1'b1;
        model_tick(en, ack_fire);
        e.tcyc = cyc + 3;
        e.fc   = m_fc[15:0];
        e.preq = m_preq;
        e.greq = m_greq;
        e.ovr  = m_ovr[7:0];
        e.lost = m_lost;
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1 pac_ack = ack_fire;
        @(posedge clk);
        #1 pac_ack = 1'b0;
        slow_in = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    task automatic do_ack(input bit p, input bit g);
        idle(2);
        pac_ack   = p;
        ghost_ack = g;
        idle($urandom_range(1, 2));
        pac_ack   = 1'b0;
        ghost_ack = 1'b0;
        if (p) m_preq = 0;
        if (g) m_greq = 0;
        @(negedge clk);
        check("ack_pac_req", pac_req, m_preq);
        check("ack_ghost_req", ghost_req, m_greq);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_tick"}, frame_tick, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_pac_req"}, pac_req, 0);
        check({tag, "_ghost_req"}, ghost_req, 0);
        check({tag, "_overrun_cnt"}, overrun_cnt, 0);
        check({tag, "_tick_lost"}, tick_lost, 0);
    endtask

    // Monitor: every frame_tick pops one expectation and checks the outputs
    // one cycle later, when the tick's effects have landed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("tick_cycle", cyc, e.tcyc);
                    @(negedge clk);
                    check("tick_width", frame_tick, 0);
                    check("frame_cnt", frame_cnt, e.fc);
                    check("pac_req", pac_req, e.preq);
                    check("ghost_req", ghost_req, e.greq);
                    check("overrun_cnt", overrun_cnt, e.ovr);
                    check("tick_lost", tick_lost, e.lost);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        checks++;
        errors++;
        $display("FAIL timeout: got no completion expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset = 1'b1; slow_in = 1'b0; enable = 1'b0; pac_ack = 1'b0; ghost_ack = 1'b0;
        model_reset();
        idle(3);
        check_all_zero("in_reset");
        reset = 1'b0;
        idle(5);
        check_all_zero("post_reset");

        // Ticks 1..15: pac acked through tick 8, ghost never acked.
        for (int i = 1; i <= 15; i++) begin
            do_tick(1'b1, 1'b0, 0);
            if (i <= 8 && m_preq) do_ack(1'b1, 1'b0);
            idle(40);
        end
        // Tick 16: pac fires while still pending and is acked in that cycle.
        do_tick(1'b1, 1'b1, 40);

        // Pause dividers for three of seven ticks.
        do_ack(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            do_tick((i < 2 || i >= 5), 1'b0, 30);
        end

        for (int i = 0; i < 60; i++) begin
            bit en, af;
            en = ($urandom_range(0, 3) != 0);
            af = ($urandom_range(0, 3) == 0);
            do_tick(en, af, $urandom_range(10, 50));
            if ($urandom_range(0, 1) == 1) do_ack($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Watchdog: silence after a tick sets tick_lost on the 100th edge.
        do_tick(1'b1, 1'b0, 0);
        repeat (WDOG - 1) @(posedge clk);
        @(negedge clk);
        check("wdog_before_limit", tick_lost, 0);
        @(posedge clk);
        @(negedge clk);
        check("wdog_at_limit", tick_lost, 1);
        m_lost = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0, 20);

        // Asynchronous reset mid-operation with slow_in left high.
        @(posedge clk);
        #3 reset = 1'b1;
        slow_in = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        idle(3);
        reset = 1'b0;
        idle(20);
        check("high_at_release_frame_cnt", frame_cnt, 0);
        slow_in = 1'b0;
        idle(5);

        // Saturation: three early pac acks leave 254 overruns before tick 580,
        // where both channels overrun together.
        for (int n = 1; n <= 620; n++) begin
            if (n == 580) begin
                @(negedge clk);
                check("ovr_before_double", overrun_cnt, 254);
                @(posedge clk);
                #1;
            end
            do_tick(1'b1, 1'b0, 6);
            if (n == 4 || n == 8 || n == 12) do_ack(1'b1, 1'b0);
        end
        idle(5);
        check("ovr_saturated", overrun_cnt, 255);

        idle(20);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
